// File: rtl/sram_sorter.sv
// Single-ported word RAM with a synchronous external port and an in-place
// bubble sorter that takes over the RAM while busy.
module sram_sorter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  start,
  input  logic                  descend,
  output logic                  busy,
  output logic                  done,
  output logic                  sorted
);

  localparam int N = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, CMP, WR_A, WR_B, FIN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   i_reg, limit_reg;
  logic                    swapped_reg, descend_reg, sorted_reg;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  logic [DATA_WIDTH-1:0]   ram [N];

  logic [ADDR_WIDTH-1:0]   i_plus;
  logic                    do_swap, pair_more, fin_cond, advance, new_pass;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;

  assign i_plus    = i_reg + 1'b1;
  // Equal words never swap, which keeps the sort stable and write-free on ties.
  assign do_swap   = descend_reg ? (a_reg < b_reg) : (a_reg > b_reg);
  assign pair_more = (i_reg < (limit_reg - 1'b1));
  assign fin_cond  = !swapped_reg || (limit_reg == ONE);

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == FIN);
  assign sorted = sorted_reg;

  always_comb begin
    state_next = state_reg;
    advance    = 1'b0;
    new_pass   = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = addr;
    ram_wdata  = data_i;
    case (state_reg)
      IDLE: begin
        ram_we = en && we;
        if (start) state_next = RD_A;
      end
      RD_A: state_next = RD_B;
      RD_B: state_next = CMP;
      CMP: begin
        if (do_swap) begin
          state_next = WR_A;
        end else begin
          advance = 1'b1;
          if (pair_more)     state_next = RD_A;
          else if (fin_cond) state_next = FIN;
          else begin
            state_next = RD_A;
            new_pass   = 1'b1;
          end
        end
      end
      WR_A: begin
        ram_we     = 1'b1;
        ram_waddr  = i_reg;
        ram_wdata  = b_reg;
        state_next = WR_B;
      end
      WR_B: begin
        ram_we    = 1'b1;
        ram_waddr = i_plus;
        ram_wdata = a_reg;
        advance   = 1'b1;
        if (pair_more)     state_next = RD_A;
        else if (fin_cond) state_next = FIN;
        else begin
          state_next = RD_A;
          new_pass   = 1'b1;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      i_reg       <= '0;
      limit_reg   <= '0;
      swapped_reg <= 1'b0;
      descend_reg <= 1'b0;
      sorted_reg  <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      data_o      <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (en && we) begin
            data_o     <= data_i;
            sorted_reg <= 1'b0;
          end else if (en) begin
            data_o <= ram[addr];
          end
          if (start) begin
            descend_reg <= descend;
            i_reg       <= '0;
            limit_reg   <= LAST;
            swapped_reg <= 1'b0;
            sorted_reg  <= 1'b0;
          end
        end
        RD_A:    a_reg <= ram[i_reg];
        RD_B:    b_reg <= ram[i_plus];
        CMP:     if (do_swap) swapped_reg <= 1'b1;
        FIN:     sorted_reg <= 1'b1;
        default: ;
      endcase
      if (advance) begin
        if (pair_more) begin
          i_reg <= i_plus;
        end else if (new_pass) begin
          limit_reg   <= limit_reg - 1'b1;
          i_reg       <= '0;
          swapped_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_sorter.sv
// Directed bench for sram_sorter: port table, sort tables and multi-cycle
// corner sequences (start-with-write, busy port, mid-sort reset, N=4 sweep).
module tb_sram_sorter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, we, start, descend;
  logic [3:0] addr;
  logic [7:0] data_i, data_o;
  logic       busy, done, sorted;

  logic        en2, we2, start2, desc2;
  logic [1:0]  addr2;
  logic [15:0] din2, dout2;
  logic        busy2, done2, sorted2;

  sram_sorter dut (
    .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr), .data_i(data_i),
    .data_o(data_o), .start(start), .descend(descend), .busy(busy),
    .done(done), .sorted(sorted)
  );

  sram_sorter #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .we(we2), .addr(addr2), .data_i(din2),
    .data_o(dout2), .start(start2), .descend(desc2), .busy(busy2),
    .done(done2), .sorted(sorted2)
  );

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } port_vec_t;

  typedef struct {
    logic [7:0] din;
    logic [7:0] desc;
    logic [7:0] asc;
  } sort_vec_t;

  port_vec_t pv[9];
  sort_vec_t sv[16];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    en = 1'b0;
    check($sformatf("%s[%0d]", name, a), data_o, exp);
  endtask

  task automatic run_sort(input logic d, input bit poke, input bit wstart,
                          input logic [3:0] wa, input logic [7:0] wd,
                          output int cycles, output int done_at);
    logic [7:0] held;
    bit hold_ok;
    int done_cnt;
    @(negedge clk);
    start = 1'b1; descend = d;
    if (wstart) begin en = 1'b1; we = 1'b1; addr = wa; data_i = wd; end
    @(posedge clk); #1;
    start = 1'b0; en = 1'b0; we = 1'b0;
    held = data_o; hold_ok = 1'b1; cycles = 0; done_at = 0; done_cnt = 0;
    if (poke) begin en = 1'b1; we = 1'b1; addr = 4'd3; data_i = 8'hFF; end
    while (busy && cycles < 3000) begin
      cycles++;
      if (done) begin done_at = cycles; done_cnt++; en = 1'b0; we = 1'b0; end
      if (data_o !== held) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    en = 1'b0; we = 1'b0;
    check("sort_finished", busy, 0);
    check("done_pulses", done_cnt, 1);
    check("data_o_held", hold_ok, 1);
    check("sorted_after", sorted, 1);
  endtask

  initial begin
    int din_l[16]  = '{34, 215, 122, 17, 77, 67, 63, 194, 139, 24, 71, 244, 246, 40, 247, 66};
    int desc_l[16] = '{247, 246, 244, 215, 194, 139, 122, 77, 71, 67, 66, 63, 40, 34, 24, 17};
    int hist[256];
    int cyc, dat, cnt;
    logic [15:0] v2_in[4];
    logic [15:0] v2_exp[4];

    for (int k = 0; k < 16; k++) begin
      sv[k].din  = 8'(din_l[k]);
      sv[k].desc = 8'(desc_l[k]);
      sv[k].asc  = 8'(desc_l[15-k]);
    end
    pv[0] = '{1'b1, 4'd0,  8'h11, 8'h11};
    pv[1] = '{1'b1, 4'd5,  8'h5A, 8'h5A};
    pv[2] = '{1'b0, 4'd0,  8'h00, 8'h11};
    pv[3] = '{1'b0, 4'd5,  8'h00, 8'h5A};
    pv[4] = '{1'b1, 4'd15, 8'hFF, 8'hFF};
    pv[5] = '{1'b0, 4'd15, 8'h00, 8'hFF};
    pv[6] = '{1'b0, 4'd0,  8'h00, 8'h11};
    pv[7] = '{1'b1, 4'd0,  8'h22, 8'h22};
    pv[8] = '{1'b0, 4'd0,  8'h00, 8'h22};
    v2_in[0]  = 16'h0100; v2_in[1]  = 16'hFFFF; v2_in[2]  = 16'h0001; v2_in[3]  = 16'h0100;
    v2_exp[0] = 16'hFFFF; v2_exp[1] = 16'h0100; v2_exp[2] = 16'h0100; v2_exp[3] = 16'h0001;

    reset = 1'b1; en = 1'b0; we = 1'b0; start = 1'b0; descend = 1'b0;
    addr = '0; data_i = '0;
    en2 = 1'b0; we2 = 1'b0; start2 = 1'b0; desc2 = 1'b0; addr2 = '0; din2 = '0;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sorted", sorted, 0);
    check("rst_data_o", data_o, 0);
    check("rst_data_o2", dout2, 0);
    @(negedge clk); reset = 1'b0;

    // Plain SRAM behaviour in IDLE
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      en = 1'b1; we = pv[k].we; addr = pv[k].addr; data_i = pv[k].din;
      @(posedge clk); #1;
      en = 1'b0; we = 1'b0;
      check($sformatf("port_vec%0d", k), data_o, pv[k].exp);
    end

    // Descending sort of the reference words
    for (int k = 0; k < 16; k++) wr(4'(k), sv[k].din);
    run_sort(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, cyc, dat);
    check("desc_done_last", dat, cyc);
    for (int k = 0; k < 16; k++) rd("desc", 4'(k), sv[k].desc);

    // Already sorted, last word written in the start cycle
    for (int k = 0; k < 15; k++) wr(4'(k), 8'(k));
    run_sort(1'b0, 1'b0, 1'b1, 4'd15, 8'd15, cyc, dat);
    check("presorted_busy_cycles", cyc, 46);
    check("presorted_done_cycle", dat, 46);
    for (int k = 0; k < 16; k++) rd("presorted", 4'(k), 8'(k));

    // All-equal words never swap
    for (int k = 0; k < 16; k++) wr(4'(k), 8'hA5);
    run_sort(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, cyc, dat);
    check("equal_busy_cycles", cyc, 46);
    check("equal_done_cycle", dat, 46);
    for (int k = 0; k < 16; k++) rd("equal", 4'(k), 8'hA5);

    // External port hammered while busy
    for (int k = 0; k < 16; k++) wr(4'(k), sv[k].din);
    run_sort(1'b0, 1'b1, 1'b0, 4'd0, 8'd0, cyc, dat);
    check("busy_port_done_last", dat, cyc);
    for (int k = 0; k < 16; k++) rd("asc", 4'(k), sv[k].asc);
    wr(4'd7, 8'd71);
    check("write_clears_sorted", sorted, 0);

    // Reset during RD_B of the second pass
    for (int k = 0; k < 16; k++) wr(4'(k), sv[k].din);
    @(negedge clk); start = 1'b1; descend = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cnt = 0;
    while (!(dut.state_reg == 3'd2 && dut.limit_reg == 4'd14) && cnt < 3000) begin
      @(posedge clk); #1; cnt++;
    end
    check("reach_pass2_rdb", (cnt < 3000), 1);
    reset = 1'b1; #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sorted", sorted, 0);
    check("midrst_data_o", data_o, 0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 256; k++) hist[k] = 0;
    for (int k = 0; k < 16; k++) hist[sv[k].din]++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); en = 1'b1; we = 1'b0; addr = 4'(k);
      @(posedge clk); #1; en = 1'b0;
      hist[data_o]--;
    end
    cnt = 0;
    for (int k = 0; k < 256; k++) if (hist[k] != 0) cnt++;
    check("midrst_permutation_bad_bins", cnt, 0);
    run_sort(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, cyc, dat);
    for (int k = 0; k < 16; k++) rd("resort", 4'(k), sv[k].desc);

    // 16-bit, 4-word instance
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); en2 = 1'b1; we2 = 1'b1; addr2 = 2'(k); din2 = v2_in[k];
      @(posedge clk); #1; en2 = 1'b0; we2 = 1'b0;
    end
    @(negedge clk); start2 = 1'b1; desc2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    cnt = 0; dat = 0;
    while (busy2 && cnt < 500) begin
      if (done2) dat++;
      @(posedge clk); #1; cnt++;
    end
    check("n4_finished", busy2, 0);
    check("n4_done_pulses", dat, 1);
    check("n4_sorted", sorted2, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); en2 = 1'b1; we2 = 1'b0; addr2 = 2'(k);
      @(posedge clk); #1; en2 = 1'b0;
      check($sformatf("n4_desc[%0d]", k), dout2, v2_exp[k]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_sorter.md
SRAM_SORTER -- requirements
Module: sram_sorter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, which sets the word width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 4, which sets the address width; depth N = 2**ADDR_WIDTH, with N >= 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port en, input, 1 bit: external port enable.
REQ-006 Port we, input, 1 bit: external write enable; a write is performed when en & we.
REQ-007 Port addr, input, ADDR_WIDTH bits: external word address.
REQ-008 Port data_i, input, DATA_WIDTH bits: external write data.
REQ-009 Port data_o, output reg, DATA_WIDTH bits: external read data, registered.
REQ-010 Port start, input, 1 bit: request a sort; sampled only in IDLE.
REQ-011 Port descend, input, 1 bit: sort order, 1 = descending, 0 = ascending; latched at start.
REQ-012 Port busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-013 Port done, output, 1 bit: one-cycle pulse when a sort completes.
REQ-014 Port sorted, output, 1 bit: registered flag; RAM is known ordered per the last latched mode.

Function
REQ-015 The block SHALL contain an internal array of N words of DATA_WIDTH bits, single-ported.
REQ-016 In IDLE, the external port SHALL behave as a synchronous SRAM with 1-cycle latency: en & we writes RAM[addr] <= data_i and data_o <= data_i; otherwise data_o <= RAM[addr].
REQ-017 While busy, the external port SHALL be ignored: no write, and data_o holds its value.
REQ-018 If start=1 in IDLE together with en & we, the write SHALL complete that cycle, and the sort SHALL operate on the updated contents.
REQ-019 The FSM states SHALL be IDLE, RD_A, RD_B, CMP, WR_A, WR_B and FIN; busy = (state != IDLE).
REQ-020 On start in IDLE, the FSM SHALL latch descend, set i=0, limit=N-1 and swapped=0, and go to RD_A on the next edge.
REQ-021 Pair-read sequence:
- RD_A reads RAM[i] into regA.
- RD_B reads RAM[i+1] into regB.
- CMP decides whether to swap.
REQ-022 Swap condition: swap when (descend_l & regA < regB) | (!descend_l & regA > regB), compared as unsigned; equal values SHALL never swap.
REQ-023 On swap, CMP SHALL go to WR_A (RAM[i] <= regB), then WR_B (RAM[i+1] <= regA), and set swapped=1.
REQ-024 After CMP with no swap, or after WR_B: if i < limit-1, then i++ and go to RD_A; otherwise the pass ends.
REQ-025 At pass end: if swapped=0 or limit=1, go to FIN; else limit--, i=0, swapped=0 and go to RD_A.
REQ-026 Cost per pair SHALL be 3 cycles without a swap and 5 cycles with a swap.
REQ-027 FIN SHALL assert done for exactly one cycle, set sorted=1, and go to IDLE next cycle.
REQ-028 sorted SHALL clear on any external write and on start; it is set only in FIN.
REQ-029 start while busy SHALL be ignored.

Reset
REQ-030 Reset asserted SHALL immediately set the state to IDLE, busy=0, done=0, sorted=0 and data_o=0, and clear i, limit, swapped, regA and regB.
REQ-031 RAM contents SHALL NOT be reset; reset mid-sort SHALL leave the RAM partially sorted, with no word lost or duplicated (a reset between WR_A and WR_B may leave RAM[i] duplicated; this is the only permitted corruption).
REQ-032 After reset deasserts, the block SHALL accept external accesses and start on the next rising edge.

Verification
REQ-033 Descending sort of the 16 default words:
- Stimulus: write RAM[0..15] = 34,215,122,17,77,67,63,194,139,24,71,244,246,40,247,66; pulse start with descend=1.
- Response: after done, reads return 247,246,244,215,194,139,122,77,71,67,66,63,40,34,24,17, and sorted=1.
REQ-034 Already-sorted input:
- Stimulus: write RAM[k] = k for k = 0..15; pulse start with descend=0.
- Response: busy is high for exactly 46 cycles (15 pairs × 3 + FIN), done pulses in the 46th cycle, and the contents are unchanged.
REQ-035 All-equal input:
- Stimulus: all words = 8'hA5; pulse start with either mode.
- Response: no RAM writes occur, and done arrives after 46 busy cycles.
REQ-036 External port ignored while busy:
- Stimulus: during a sort, drive en=1, we=1, addr=3, data_i=8'hFF.
- Response: RAM[3] is not written, data_o holds, sorted=1 at FIN, and a subsequent write to any address clears sorted.
REQ-037 Reset mid-operation:
- Stimulus: assert reset during RD_B of pass 2.
- Response: busy=0, done=0, sorted=0 and data_o=0 immediately; RAM contents are a permutation of the input.
- Follow-up: a new start then completes a correct sort.
REQ-038 Parameter sweep: repeat REQ-033 with DATA_WIDTH=16 and ADDR_WIDTH=2 (N=4) using 16'h0100, 16'hFFFF, 16'h0001, 16'h0100 -> descending result FFFF, 0100, 0100, 0001.
